// File: rtl/sobel_window_if.sv
// Pixel-column input and gradient-result output bundle for sobel_window.
interface sobel_window_if #(
    parameter int WIDTH = 12
);
    logic             in_valid;
    logic             sof;
    logic [WIDTH-1:0] row0;
    logic [WIDTH-1:0] row1;
    logic [WIDTH-1:0] row2;
    logic             kernel_sel;
    logic             out_valid;
    logic [WIDTH-1:0] out_pixel;
    logic             out_eol;

    modport master (
        output in_valid, sof, row0, row1, row2, kernel_sel,
        input  out_valid, out_pixel, out_eol
    );

    modport slave (
        input  in_valid, sof, row0, row1, row2, kernel_sel,
        output out_valid, out_pixel, out_eol
    );
endinterface

// File: rtl/sobel_window.sv
// 3x3 Sobel window: column shift array with frame position tracking, then
// gradient and saturated-magnitude pipeline stages.
module sobel_window #(
    parameter int WIDTH  = 12,
    parameter int LINE_W = 640,
    parameter int LINE_H = 480
) (
    input  logic          clk,
    input  logic          rst_n,
    sobel_window_if.slave bus
);
    localparam int SW = WIDTH + 3;
    localparam int CW = 12;
    localparam logic [CW-1:0] COL_LAST = CW'(LINE_W - 1);
    localparam logic [CW-1:0] ROW_LAST = CW'(LINE_H - 1);

    // win_q[r][c]: r 0 = top (row2), 2 = bottom (row0); c 2 = newest column
    logic [2:0][2:0][WIDTH-1:0] win_q;
    logic [CW-1:0]              col_q, col_d, row_q, row_d;
    logic [CW-1:0]              pos_col_s, pos_row_s;
    logic                       win_ok_s;
    logic                       v1_q, eol1_q, ks1_q;
    logic signed [SW-1:0]       gx_s, gy_s, g_s, g_q;
    logic                       v2_q, eol2_q;
    logic signed [SW-1:0]       mag_s;
    logic [WIDTH-1:0]           pix_s;
    logic                       out_valid_q, out_eol_q;
    logic [WIDTH-1:0]           out_pixel_q;

    function automatic logic signed [SW-1:0] ext(input logic [WIDTH-1:0] p);
        return $signed({3'b000, p});
    endfunction

    // Position of the pixel being accepted and the position of the next one.
    always_comb begin
        pos_col_s = bus.sof ? {CW{1'b0}} : col_q;
        pos_row_s = bus.sof ? {CW{1'b0}} : row_q;
        col_d     = col_q;
        row_d     = row_q;
        if (bus.in_valid) begin
            if (pos_col_s == COL_LAST) begin
                col_d = {CW{1'b0}};
                row_d = (pos_row_s == ROW_LAST) ? {CW{1'b0}} : pos_row_s + 12'd1;
            end else begin
                col_d = pos_col_s + 12'd1;
                row_d = pos_row_s;
            end
        end else begin
            col_d = col_q;
            row_d = row_q;
        end
        win_ok_s = bus.in_valid && (pos_col_s >= 12'd2) && (pos_row_s >= 12'd2);
    end

    // Stage 1: window shift, position counters, per-pixel valid/eol/kernel tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q  <= '0;
            col_q  <= '0;
            row_q  <= '0;
            v1_q   <= 1'b0;
            eol1_q <= 1'b0;
            ks1_q  <= 1'b0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            v1_q   <= win_ok_s;
            eol1_q <= win_ok_s && (pos_col_s == COL_LAST);
            if (bus.in_valid) begin
                for (int r = 0; r < 3; r++) begin
                    win_q[r][0] <= win_q[r][1];
                    win_q[r][1] <= win_q[r][2];
                end
                win_q[0][2] <= bus.row2;
                win_q[1][2] <= bus.row1;
                win_q[2][2] <= bus.row0;
                ks1_q       <= bus.kernel_sel;
            end else begin
                win_q <= win_q;
                ks1_q <= ks1_q;
            end
        end
    end

    // Both gradients in WIDTH+3 signed bits; max magnitude 4*(2^WIDTH-1) fits.
    always_comb begin
        gx_s = (ext(win_q[0][2]) + (ext(win_q[1][2]) <<< 1) + ext(win_q[2][2]))
             - (ext(win_q[0][0]) + (ext(win_q[1][0]) <<< 1) + ext(win_q[2][0]));
        gy_s = (ext(win_q[2][0]) + (ext(win_q[2][1]) <<< 1) + ext(win_q[2][2]))
             - (ext(win_q[0][0]) + (ext(win_q[0][1]) <<< 1) + ext(win_q[0][2]));
        g_s  = ks1_q ? gy_s : gx_s;
    end

    // Stage 2: registered gradient.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_q    <= '0;
            v2_q   <= 1'b0;
            eol2_q <= 1'b0;
        end else begin
            g_q    <= g_s;
            v2_q   <= v1_q;
            eol2_q <= eol1_q;
        end
    end

    // Absolute value, clamped to the pixel range.
    always_comb begin
        mag_s = g_q[SW-1] ? -g_q : g_q;
        if (|mag_s[SW-1:WIDTH]) begin
            pix_s = {WIDTH{1'b1}};
        end else begin
            pix_s = mag_s[WIDTH-1:0];
        end
    end

    // Stage 3: registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_eol_q   <= 1'b0;
            out_pixel_q <= '0;
        end else begin
            out_valid_q <= v2_q;
            out_eol_q   <= v2_q && eol2_q;
            out_pixel_q <= v2_q ? pix_s : out_pixel_q;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_eol   = out_eol_q;
    assign bus.out_pixel = out_pixel_q;
endmodule
